// File: rtl/fifo_pkt_reader.sv
// -----------------------------------------------------------------------------
// fifo_pkt_reader
//
// Pops bytes from a non-show-ahead FIFO one at a time and forwards them on a
// valid/ready byte stream, grouping every PKT_LEN data bytes into a packet that
// is closed by an XOR checksum byte (flagged with out_last). A 16-bit counter
// tracks completed packets.
//
// Parameters:
//   PKT_LEN    data bytes per packet (1..255)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   ENrd       read enable, only looked at between bytes (IDLE)
//   empty      FIFO empty flag
//   q          FIFO read data, valid the cycle after rdreq
//   rdreq      FIFO read request, one-cycle pulse per byte
//   out_data   stream byte (data or checksum)
//   out_valid  out_data is valid
//   out_last   current byte is the packet checksum
//   out_ready  sink accepts the byte on out_valid && out_ready
//   pkt_cnt    completed packet count, wraps at 0xFFFF
// -----------------------------------------------------------------------------
module fifo_pkt_reader #(
    parameter int unsigned PKT_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ENrd,
    input  logic        empty,
    input  logic [7:0]  q,
    output logic        rdreq,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] pkt_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_SEND = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    localparam logic [7:0] PKT_LEN_C = 8'(PKT_LEN);

    state_t      state_r;
    logic [7:0]  byte_cnt_r;
    logic [7:0]  csum_r;
    logic [7:0]  out_data_r;
    logic        rdreq_r;
    logic        out_valid_r;
    logic        out_last_r;
    logic [15:0] pkt_cnt_r;

    // Running XOR checksum update.
    function automatic logic [7:0] csum_upd(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Packet FSM: every output is registered and set on the transition into
    // the state that owns it, so nothing combinational reaches the ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            byte_cnt_r  <= 8'd0;
            csum_r      <= 8'd0;
            out_data_r  <= 8'd0;
            rdreq_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            pkt_cnt_r   <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Sole reader of the FIFO, so !empty here makes the pop legal.
                    if (ENrd && !empty) begin
                        state_r <= ST_RD;
                        rdreq_r <= 1'b1;
                    end
                end
                ST_RD: begin
                    state_r <= ST_CAP;
                    rdreq_r <= 1'b0;
                end
                ST_CAP: begin
                    // q is valid now: one cycle after the rdreq pulse.
                    out_data_r  <= q;
                    csum_r      <= csum_upd(csum_r, q);
                    byte_cnt_r  <= byte_cnt_r + 8'd1;
                    out_valid_r <= 1'b1;
                    out_last_r  <= 1'b0;
                    state_r     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (byte_cnt_r == PKT_LEN_C) begin
                            out_data_r <= csum_r;
                            out_last_r <= 1'b1;
                            state_r    <= ST_CSUM;
                        end else begin
                            out_valid_r <= 1'b0;
                            state_r     <= ST_IDLE;
                        end
                    end
                end
                ST_CSUM: begin
                    if (out_ready) begin
                        csum_r      <= 8'd0;
                        byte_cnt_r  <= 8'd0;
                        pkt_cnt_r   <= pkt_cnt_r + 16'd1;
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rdreq_r     <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rdreq     = rdreq_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign pkt_cnt   = pkt_cnt_r;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_pkt_reader
//
// Directed + randomized bench for fifo_pkt_reader. A queue models the FIFO
// (non-show-ahead: q updates after the rdreq edge), and the expected stream is
// built from the pushed bytes: each group of PKT_LEN bytes followed by the XOR
// of that group with out_last set. dut0 uses PKT_LEN=4, dut1 uses PKT_LEN=1.
// -----------------------------------------------------------------------------
module tb_fifo_pkt_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en0, empty0, out_ready0, rdreq0, out_valid0, out_last0;
    logic [7:0]  q0, out_data0;
    logic [15:0] pkt_cnt0;
    logic        en1, empty1, out_ready1, rdreq1, out_valid1, out_last1;
    logic [7:0]  q1, out_data1;
    logic [15:0] pkt_cnt1;

    fifo_pkt_reader #(.PKT_LEN(4)) dut0 (
        .clk(clk), .rst(rst), .ENrd(en0), .empty(empty0), .q(q0),
        .rdreq(rdreq0), .out_data(out_data0), .out_valid(out_valid0),
        .out_last(out_last0), .out_ready(out_ready0), .pkt_cnt(pkt_cnt0)
    );

    fifo_pkt_reader #(.PKT_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .ENrd(en1), .empty(empty1), .q(q1),
        .rdreq(rdreq1), .out_data(out_data1), .out_valid(out_valid1),
        .out_last(out_last1), .out_ready(out_ready1), .pkt_cnt(pkt_cnt1)
    );

    int n_vec = 0;
    int n_err = 0;

    byte unsigned fifo0[$], fifo1[$], sent0[$], sent1[$], pend[$];
    logic [8:0]   rx0[$], rx1[$];
    int cyc, rd0_cnt, rd1_cnt, pkts0, pkts1;
    int first_rd_cyc, first_val_cyc, last_hs_cyc, rd_before;
    bit found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rx0.delete(); rx1.delete(); sent0.delete(); sent1.delete();
        rd0_cnt = 0; rd1_cnt = 0; pkts0 = 0; pkts1 = 0;
        first_rd_cyc = -1; first_val_cyc = -1; last_hs_cyc = -1;
    endtask

    task automatic push0(input byte unsigned b);
        fifo0.push_back(b); sent0.push_back(b); empty0 = 1'b0;
    endtask

    task automatic push1(input byte unsigned b);
        fifo1.push_back(b); sent1.push_back(b); empty1 = 1'b0;
    endtask

    // One clock: sample outputs at the falling edge, let the edge happen, then
    // update the FIFO model just after the rising edge.
    task automatic tick();
        logic r0, r1;
        r0 = rdreq0;
        r1 = rdreq1;
        if (r0) begin
            chk("rdreq0_nonempty", 32'(fifo0.size() != 0), 32'd1);
            rd0_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (r1) begin
            chk("rdreq1_nonempty", 32'(fifo1.size() != 0), 32'd1);
            rd1_cnt++;
        end
        if (out_valid0 && first_val_cyc < 0) first_val_cyc = cyc;
        if (out_valid0 && out_ready0) begin
            rx0.push_back({out_last0, out_data0});
            if (out_last0) begin pkts0++; last_hs_cyc = cyc; end
        end
        if (out_valid1 && out_ready1) begin
            rx1.push_back({out_last1, out_data1});
            if (out_last1) pkts1++;
        end
        @(posedge clk);
        #1;
        if (r0 && fifo0.size() != 0) q0 = fifo0.pop_front();
        if (r1 && fifo1.size() != 0) q1 = fifo1.pop_front();
        empty0 = (fifo0.size() == 0);
        empty1 = (fifo1.size() == 0);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_pkts(input int which, input int n, input int budget, input string tag);
        int b;
        b = budget;
        while (((which == 0) ? pkts0 : pkts1) < n && b > 0) begin
            tick();
            b--;
        end
        chk(tag, 32'(((which == 0) ? pkts0 : pkts1) >= n), 32'd1);
    endtask

    // Reference: expected stream = data bytes, with XOR of each group of plen
    // bytes appended and flagged last.
    task automatic cmp_stream(input string tag, input logic [8:0] got[$],
                              input byte unsigned sent[$], input int plen);
        logic [8:0] exp[$];
        byte unsigned x;
        int n;
        x = 8'h00;
        for (int i = 0; i < sent.size(); i++) begin
            exp.push_back({1'b0, sent[i]});
            x = x ^ sent[i];
            if ((i + 1) % plen == 0) begin
                exp.push_back({1'b1, x});
                x = 8'h00;
            end
        end
        chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
    endtask

    initial begin
        rst = 1'b1;
        en0 = 1'b0; empty0 = 1'b1; out_ready0 = 1'b0; q0 = 8'h00;
        en1 = 1'b0; empty1 = 1'b1; out_ready1 = 1'b0; q1 = 8'h00;
        cyc = 0;
        clr();
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("reset0", {5'd0, rdreq0, out_valid0, out_last0, out_data0, pkt_cnt0}, 32'd0);
        chk("reset1", {5'd0, rdreq1, out_valid1, out_last1, out_data1, pkt_cnt1}, 32'd0);

        // Basic packet
        clr();
        push0(8'h11); push0(8'h22); push0(8'h44); push0(8'h88);
        en0 = 1'b1; out_ready0 = 1'b1;
        wait_pkts(0, 1, 100, "basic_timeout");
        tick();
        cmp_stream("basic", rx0, sent0, 4);
        chk("basic_pkt_cnt", 32'(pkt_cnt0), 32'd1);
        chk("basic_rdreq_pulses", 32'(rd0_cnt), 32'd4);
        chk("basic_first_valid_lat", 32'(first_val_cyc - first_rd_cyc), 32'd2);
        // 17 cycles including the IDLE decision cycle before the first rdreq
        chk("basic_pkt_cycles", 32'(last_hs_cyc - first_rd_cyc + 2), 32'd17);

        // Back-pressure while 0x22 is presented
        clr();
        push0(8'h11); push0(8'h22); push0(8'h44); push0(8'h88);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (out_valid0 && out_data0 == 8'h22) found = 1'b1;
            else tick();
        end
        chk("bp_found_22", 32'(found), 32'd1);
        out_ready0 = 1'b0;
        rd_before = rd0_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold", {21'd0, out_valid0, out_last0, rdreq0, out_data0}, {21'd0, 3'b100, 8'h22});
        end
        chk("bp_no_extra_rdreq", 32'(rd0_cnt), 32'(rd_before));
        out_ready0 = 1'b1;
        wait_pkts(0, 1, 100, "bp_timeout");
        tick();
        cmp_stream("bp", rx0, sent0, 4);
        chk("bp_pkt_cnt", 32'(pkt_cnt0), 32'd2);

        // Empty/enable gating
        clr();
        for (int i = 0; i < 50; i++) tick();
        chk("empty_no_rdreq", 32'(rd0_cnt), 32'd0);
        chk("empty_no_valid", 32'(out_valid0), 32'd0);
        for (int i = 0; i < 4; i++) push0(8'($urandom_range(0, 255)));
        for (int i = 0; i < 100 && rx0.size() < 2; i++) tick();
        en0 = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("gate_rdreq_count", 32'(rd0_cnt), 32'd2);
        chk("gate_rx_count", 32'(rx0.size()), 32'd2);
        en0 = 1'b1;
        wait_pkts(0, 1, 100, "gate_timeout");
        tick();
        cmp_stream("gate", rx0, sent0, 4);
        chk("gate_pkt_cnt", 32'(pkt_cnt0), 32'd3);

        // Reset during CAP of byte 3
        clr();
        push0(8'h55); push0(8'h66); push0(8'h77); push0(8'h99);
        for (int i = 0; i < 100 && rd0_cnt < 3; i++) tick();
        rst = 1'b1;
        fifo0.delete(); empty0 = 1'b1;
        tick();
        chk("midrst_outputs", {5'd0, rdreq0, out_valid0, out_last0, out_data0, pkt_cnt0}, 32'd0);
        rst = 1'b0;
        tick();
        clr();
        push0(8'h01); push0(8'h02); push0(8'h03); push0(8'h04);
        wait_pkts(0, 1, 100, "midrst_timeout");
        tick();
        cmp_stream("midrst", rx0, sent0, 4);
        chk("midrst_csum", 32'(rx0.size() == 5 ? rx0[4] : 9'h000), 32'h104);
        chk("midrst_pkt_cnt", 32'(pkt_cnt0), 32'd1);

        // pkt_cnt wrap with PKT_LEN=1
        clr();
        force dut1.pkt_cnt_r = 16'hFFFF;
        tick();
        release dut1.pkt_cnt_r;
        tick();
        chk("wrap_preset", 32'(pkt_cnt1), 32'h0000FFFF);
        push1(8'hA5);
        en1 = 1'b1; out_ready1 = 1'b1;
        wait_pkts(1, 1, 100, "wrap_timeout");
        tick();
        chk("wrap_pkt_cnt", 32'(pkt_cnt1), 32'd0);
        cmp_stream("len1", rx1, sent1, 1);

        // Randomized: trickling FIFO, random back-pressure and enable
        clr();
        for (int i = 0; i < 32; i++) pend.push_back(8'($urandom_range(0, 255)));
        for (int c = 0; c < 4000 && pkts0 < 8; c++) begin
            if (pend.size() != 0 && $urandom_range(0, 1) == 1) push0(pend.pop_front());
            out_ready0 = ($urandom_range(0, 3) != 0);
            en0 = ($urandom_range(0, 7) != 0);
            tick();
        end
        chk("rand_done", 32'(pkts0), 32'd8);
        out_ready0 = 1'b1;
        tick();
        cmp_stream("rand", rx0, sent0, 4);
        chk("rand_rdreq_count", 32'(rd0_cnt), 32'd32);
        chk("rand_pkt_cnt", 32'(pkt_cnt0), 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
